e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the five-stage MIPS pipeline with CP0 exceptions. It consumes the decoded MDU operation and the forwarded rs/rt operands of the instruction currently held in the D→E pipeline register. It owns the HI/LO registers and runs multi-cycle mult/div operations. It exports Start/Busy to the hazard unit, which stalls any MDU-class instruction in D, and it supplies HI/LO read data to the E-stage result mux.

---
 rtl/e_mdu_pkg.sv | 20 ++
 rtl/e_mdu.sv | 136 +++++++++++++
 tb/tb_e_mdu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDU op encodings and default latencies.
// Imported by the E-stage MDU and by the decoder.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Owns HI/LO and models multi-cycle mult/div latency.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDUOut
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  mdu_op_e op;
  assign op = mdu_op_e'(E_MDUOp);

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;

  assign is_mult  = (op == MDU_MULT);
  assign is_multu = (op == MDU_MULTU);
  assign is_div   = (op == MDU_DIV);
  assign is_divu  = (op == MDU_DIVU);
  assign is_mfhi  = (op == MDU_MFHI);
  assign is_mflo  = (op == MDU_MFLO);
  assign is_mthi  = (op == MDU_MTHI);
  assign is_mtlo  = (op == MDU_MTLO);

  logic [31:0] hi, lo;
  logic [31:0] temp_hi, temp_lo;
  logic [CW-1:0] cnt;
  logic busy;
  logic dz;

  logic any_md;
  assign any_md  = is_mult | is_multu | is_div | is_divu;
  assign E_Start = any_md & ~Req & ~busy;
  assign E_Busy  = busy;

  // A divisor of 1 stands in for zero (result dropped) and for the
  // 0x80000000 / -1 overflow case, which then yields the right answer.
  logic ovf, zero_dv;
  logic [31:0] dvs;
  assign zero_dv = (E_V2 == 32'd0);
  assign ovf = (E_V1 == 32'h8000_0000) && (E_V2 == 32'hffff_ffff);
  assign dvs = (zero_dv | ovf) ? 32'd1 : E_V2;

  logic signed [31:0] sq, sr;
  logic [31:0] uq, ur;
  logic [63:0] ps, pu;

  assign sq = $signed(E_V1) / $signed(dvs);
  assign sr = $signed(E_V1) % $signed(dvs);
  assign uq = E_V1 / dvs;
  assign ur = E_V1 % dvs;
  assign ps = {{32{E_V1[31]}}, E_V1} * {{32{E_V2[31]}}, E_V2};
  assign pu = {32'd0, E_V1} * {32'd0, E_V2};

  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    unique case (1'b1)
      is_mult: begin
        res_hi = ps[63:32];
        res_lo = ps[31:0];
      end
      is_multu: begin
        res_hi = pu[63:32];
        res_lo = pu[31:0];
      end
      is_div: begin
        res_hi = sr;
        res_lo = sq;
      end
      is_divu: begin
        res_hi = ur;
        res_lo = uq;
      end
      default: ;
    endcase
  end

  always_comb begin
    E_MDUOut = '0;
    unique case (1'b1)
      is_mfhi: E_MDUOut = hi;
      is_mflo: E_MDUOut = lo;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      dz      <= 1'b0;
    end else if (busy) begin
      // In-flight op finishes regardless of Req.
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (!dz) begin
          hi <= temp_hi;
          lo <= temp_lo;
        end
      end
    end else if (E_Start) begin
      temp_hi <= res_hi;
      temp_lo <= res_lo;
      busy    <= 1'b1;
      cnt     <= (is_mult | is_multu) ? CW'(MULT_CYCLES)
                                      : CW'(DIV_CYCLES);
      dz      <= (is_div | is_divu) & zero_dv;
    end else if (!Req) begin
      if (is_mthi) hi <= E_V1;
      if (is_mtlo) lo <= E_V1;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed scoreboard bench for e_mdu.
// Expected values are queued at drive time and popped at check time.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        Req;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_MDUOut;

  int n_chk;
  int n_fail;
  logic [31:0] exp_q[$];

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .Req      (Req),
    .E_MDUOp  (E_MDUOp),
    .E_V1     (E_V1),
    .E_V2     (E_V2),
    .E_Start  (E_Start),
    .E_Busy   (E_Busy),
    .E_MDUOut (E_MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, expected value missing", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h, expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    logic md;
    @(negedge clk);
    E_MDUOp = op;
    E_V1    = a;
    E_V2    = b;
    Req     = r;
    #1;
    md = (op == MDU_MULT) || (op == MDU_MULTU) ||
         (op == MDU_DIV)  || (op == MDU_DIVU);
    // Upstream stall must keep mult/div out of E while busy.
    if (md) begin
      push(32'd0);
      chk("no_md_while_busy", {31'd0, E_Busy});
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi,
                           input logic [31:0] lo);
    drive(MDU_MFHI, 32'd0, 32'd0, 1'b0);
    push(hi);
    chk({tag, "_hi"}, E_MDUOut);
    drive(MDU_MFLO, 32'd0, 32'd0, 1'b0);
    push(lo);
    chk({tag, "_lo"}, E_MDUOut);
  endtask

  task automatic run_md(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n, input int req_at,
                        input logic [31:0] hi, input logic [31:0] lo);
    drive(op, a, b, 1'b0);
    push(32'd1);
    chk({tag, "_start"}, {31'd0, E_Start});
    for (int i = 1; i <= n; i++) begin
      drive(MDU_NONE, 32'd0, 32'd0, (i == req_at));
      push(32'd1);
      chk({tag, "_busy"}, {31'd0, E_Busy});
    end
    drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
    push(32'd0);
    chk({tag, "_done"}, {31'd0, E_Busy});
    read_hilo(tag, hi, lo);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    Req     = 1'b0;
    E_MDUOp = MDU_NONE;
    E_V1    = '0;
    E_V2    = '0;
    repeat (2) @(negedge clk);
    #1;
    push(32'd0); chk("rst_busy", {31'd0, E_Busy});
    push(32'd0); chk("rst_start", {31'd0, E_Start});
    push(32'd0); chk("rst_out", E_MDUOut);
    @(negedge clk);
    reset = 1'b0;
    read_hilo("rst", 32'd0, 32'd0);

    run_md("mult", MDU_MULT, 32'hffff_fffe, 32'd3, 5, 0,
           32'hffff_ffff, 32'hffff_fffa);
    run_md("multu", MDU_MULTU, 32'hffff_fffe, 32'd3, 5, 0,
           32'h0000_0002, 32'hffff_fffa);
    run_md("div", MDU_DIV, 32'hffff_fff9, 32'd2, 10, 0,
           32'hffff_ffff, 32'hffff_fffd);
    run_md("divu", MDU_DIVU, 32'd7, 32'd2, 10, 0,
           32'd1, 32'd3);
    run_md("div_ovf", MDU_DIV, 32'h8000_0000, 32'hffff_ffff, 10, 0,
           32'd0, 32'h8000_0000);
    run_md("div0", MDU_DIV, 32'd1234, 32'd0, 10, 0,
           32'd0, 32'h8000_0000);

    drive(MDU_MULT, 32'd5, 32'd5, 1'b1);
    push(32'd0); chk("req_start", {31'd0, E_Start});
    drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
    push(32'd0); chk("req_busy", {31'd0, E_Busy});
    read_hilo("req", 32'd0, 32'h8000_0000);

    run_md("mult_req", MDU_MULT, 32'd6, 32'd7, 5, 2,
           32'd0, 32'd42);

    drive(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    drive(MDU_MFHI, 32'd0, 32'd0, 1'b0);
    push(32'h1234_5678); chk("mthi_mfhi", E_MDUOut);
    drive(MDU_MTLO, 32'hdead_beef, 32'd0, 1'b1);
    drive(MDU_MFLO, 32'd0, 32'd0, 1'b0);
    push(32'd42); chk("mtlo_req", E_MDUOut);

    drive(MDU_DIV, 32'd100, 32'd7, 1'b0);
    push(32'd1); chk("rdiv_start", {31'd0, E_Start});
    drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
    drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
    push(32'd1); chk("rdiv_busy", {31'd0, E_Busy});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    push(32'd0); chk("rdiv_busy0", {31'd0, E_Busy});
    read_hilo("rdiv", 32'd0, 32'd0);
    repeat (12) drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
    read_hilo("rdiv_late", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
